// File: rtl/mem_req_tracker_pkg.sv
// Shared types for the memory request tracker: request kinds, the
// queued tag entry, and the legacy MIPS word/register typedefs.
package mem_pkg;

    typedef logic [15:0] mips_word;
    typedef logic [2:0]  mips_reg;

    // Request kinds as they appear on the req_kind bus; 2'b11 is never accepted.
    typedef enum logic [1:0] {
        KIND_FETCH   = 2'b00,
        KIND_LOAD    = 2'b01,
        KIND_STORE   = 2'b10,
        KIND_ILLEGAL = 2'b11
    } mem_kind_e;

    // Tag kept for each outstanding request at the default destination width.
    typedef struct packed {
        mem_kind_e kind;
        mips_reg   dest;
    } mem_entry_t;

    function automatic logic kind_is_legal(input mem_kind_e kind);
        return kind != KIND_ILLEGAL;
    endfunction

endpackage

// File: rtl/mem_req_tracker_tag_fifo.sv
// tag_fifo: synchronous FIFO of tracker entries with occupancy count.
// Pointers wrap modulo DEPTH (power of two); full/empty come from the count.
module tag_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = mem_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  entry_t           wr_entry_i,
    output entry_t           rd_entry_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign rd_entry_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    // Pointer and occupancy next-state; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    // Pointer/count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_entry_i;
    end

endmodule

// File: rtl/mem_req_tracker.sv
// mem_req_tracker: forwards fetch/load/store requests to memory with zero
// latency, tracks up to DEPTH in-order outstanding operations, and routes
// each in-order response to a registered fetch/load/store completion pulse.
// Optional MEM_REQ_TRACKER_STATS_EN adds 32-bit per-kind completion counters.
module mem_req_tracker
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DEST_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_kind,
    input  logic [DEST_W-1:0]        req_dest,
    input  logic [WIDTH-1:0]         req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     mem_req_valid,
    output logic                     mem_req_we,
    output logic [WIDTH-1:0]         mem_req_addr,
    output logic [WIDTH-1:0]         mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [WIDTH-1:0]         mem_resp_rdata,
    output logic                     fetch_resp_valid,
    output logic                     ld_resp_valid,
    output logic                     st_resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [DEST_W-1:0]        resp_dest,
`ifdef MEM_REQ_TRACKER_STATS_EN
    output logic [31:0]              fetch_cnt,
    output logic [31:0]              ld_cnt,
    output logic [31:0]              st_cnt,
`endif
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_sticky
);

    // Entry carries the configured destination width rather than the default.
    typedef struct packed {
        mem_kind_e         kind;
        logic [DEST_W-1:0] dest;
    } entry_t;

    mem_kind_e   kind_e;
    entry_t      push_entry, head_entry;
    logic        kind_legal, accept, resp_fire, resp_unexp;
    logic        fifo_full, fifo_empty;

    logic              fetch_q, fetch_d;
    logic              ld_q, ld_d;
    logic              st_q, st_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              err_q, err_d;

    assign kind_e     = mem_kind_e'(req_kind);
    assign kind_legal = kind_is_legal(kind_e);
    assign req_ready  = !fifo_full;
    assign accept     = req_valid && req_ready && kind_legal;
    assign resp_fire  = mem_resp_valid && !fifo_empty;
    assign resp_unexp = mem_resp_valid && fifo_empty;

    assign mem_req_valid = accept;
    assign mem_req_we    = accept && (kind_e == KIND_STORE);
    assign mem_req_addr  = req_addr;
    assign mem_req_wdata = req_wdata;

    assign push_entry.kind = kind_e;
    assign push_entry.dest = req_dest;

    tag_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (accept),
        .pop_i      (resp_fire),
        .wr_entry_i (push_entry),
        .rd_entry_o (head_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (outstanding)
    );

    // Classify the popped head into one completion pulse and capture data/tag.
    always_comb begin
        fetch_d = 1'b0;
        ld_d    = 1'b0;
        st_d    = 1'b0;
        data_d  = data_q;
        dest_d  = dest_q;
        err_d   = err_q | (req_valid && !kind_legal) | resp_unexp;
        if (resp_fire) begin
            data_d = mem_resp_rdata;
            unique case (head_entry.kind)
                KIND_FETCH: fetch_d = 1'b1;
                KIND_LOAD: begin
                    ld_d   = 1'b1;
                    dest_d = head_entry.dest;
                end
                KIND_STORE: st_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Completion and error registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_q <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            fetch_q <= fetch_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    assign fetch_resp_valid = fetch_q;
    assign ld_resp_valid    = ld_q;
    assign st_resp_valid    = st_q;
    assign resp_data        = data_q;
    assign resp_dest        = dest_q;
    assign err_sticky       = err_q;

`ifdef MEM_REQ_TRACKER_STATS_EN
    logic [31:0] fetch_cnt_q, ld_cnt_q, st_cnt_q;

    // Per-kind counters advance on the same edge that raises the matching pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            if (fetch_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (ld_d)    ld_cnt_q    <= ld_cnt_q + 32'd1;
            if (st_d)    st_cnt_q    <= st_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign ld_cnt    = ld_cnt_q;
    assign st_cnt    = st_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_tracker.sv
// Bench for mem_req_tracker: queue-based reference model checked every
// negedge, directed scenarios with literal expectations, then random traffic.
module tb_mem_req_tracker;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int DEST_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_kind = 2'b00;
    logic [DEST_W-1:0] req_dest = '0;
    logic [WIDTH-1:0]  req_addr = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic              mem_req_valid, mem_req_we;
    logic [WIDTH-1:0]  mem_req_addr, mem_req_wdata;
    logic              mem_resp_valid = 1'b0;
    logic [WIDTH-1:0]  mem_resp_rdata = '0;
    logic              fetch_resp_valid, ld_resp_valid, st_resp_valid;
    logic [WIDTH-1:0]  resp_data;
    logic [DEST_W-1:0] resp_dest;
    logic [2:0]        outstanding;
    logic              err_sticky;
`ifdef MEM_REQ_TRACKER_STATS_EN
    logic [31:0]       fetch_cnt, ld_cnt, st_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_req_tracker #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .DEST_W (DEST_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_kind         (req_kind),
        .req_dest         (req_dest),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .mem_req_valid    (mem_req_valid),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_rdata   (mem_resp_rdata),
        .fetch_resp_valid (fetch_resp_valid),
        .ld_resp_valid    (ld_resp_valid),
        .st_resp_valid    (st_resp_valid),
        .resp_data        (resp_data),
        .resp_dest        (resp_dest),
`ifdef MEM_REQ_TRACKER_STATS_EN
        .fetch_cnt        (fetch_cnt),
        .ld_cnt           (ld_cnt),
        .st_cnt           (st_cnt),
`endif
        .outstanding      (outstanding),
        .err_sticky       (err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          kq[$];
    logic [2:0]  dq[$];
    logic        m_fetch = 1'b0, m_ld = 1'b0, m_st = 1'b0, m_err = 1'b0;
    logic [15:0] m_data = '0;
    logic [2:0]  m_dest = '0;
    int unsigned m_fc = 0, m_lc = 0, m_sc = 0;
    int          m_occ, m_k;
    logic [2:0]  m_d;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            kq.delete();
            dq.delete();
            m_fetch <= 1'b0; m_ld <= 1'b0; m_st <= 1'b0; m_err <= 1'b0;
            m_data <= '0; m_dest <= '0;
            m_fc <= 0; m_lc <= 0; m_sc <= 0;
        end else begin
            m_occ = kq.size();
            m_fetch <= 1'b0; m_ld <= 1'b0; m_st <= 1'b0;
            if (req_valid && req_kind == 2'b11) m_err <= 1'b1;
            if (mem_resp_valid && m_occ == 0) m_err <= 1'b1;
            if (mem_resp_valid && m_occ > 0) begin
                m_k = kq.pop_front();
                m_d = dq.pop_front();
                m_data <= mem_resp_rdata;
                if (m_k == 0) begin m_fetch <= 1'b1; m_fc <= m_fc + 1; end
                if (m_k == 1) begin m_ld <= 1'b1; m_lc <= m_lc + 1; m_dest <= m_d; end
                if (m_k == 2) begin m_st <= 1'b1; m_sc <= m_sc + 1; end
            end
            if (req_valid && req_kind != 2'b11 && m_occ < DEPTH) begin
                kq.push_back(int'(req_kind));
                dq.push_back(req_dest);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic e_acc;
    always @(negedge clk) begin
        e_acc = req_valid && req_kind != 2'b11 && (kq.size() < DEPTH);
        chk("req_ready",   32'(req_ready),   32'(kq.size() < DEPTH));
        chk("outstanding", 32'(outstanding), 32'(kq.size()));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(e_acc));
        if (e_acc) begin
            chk("mem_req_we",    32'(mem_req_we),    32'(req_kind == 2'b10));
            chk("mem_req_addr",  32'(mem_req_addr),  32'(req_addr));
            chk("mem_req_wdata", 32'(mem_req_wdata), 32'(req_wdata));
        end
        chk("fetch_resp_valid", 32'(fetch_resp_valid), 32'(m_fetch));
        chk("ld_resp_valid",    32'(ld_resp_valid),    32'(m_ld));
        chk("st_resp_valid",    32'(st_resp_valid),    32'(m_st));
        chk("resp_data",        32'(resp_data),        32'(m_data));
        chk("resp_dest",        32'(resp_dest),        32'(m_dest));
        chk("err_sticky",       32'(err_sticky),       32'(m_err));
`ifdef MEM_REQ_TRACKER_STATS_EN
        chk("fetch_cnt", fetch_cnt, m_fc);
        chk("ld_cnt",    ld_cnt,    m_lc);
        chk("st_cnt",    st_cnt,    m_sc);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid      = 1'b0;
        req_kind       = 2'b00;
        mem_resp_valid = 1'b0;
    endtask

    task automatic req(input logic [1:0] k, input logic [2:0] d, input logic [15:0] a);
        req_valid = 1'b1;
        req_kind  = k;
        req_dest  = d;
        req_addr  = a;
        req_wdata = a ^ 16'h5A5A;
    endtask

    task automatic resp(input logic [15:0] r);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = r;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    logic [1:0]  t2_kind [4];
    logic [2:0]  t2_dest [4];

    initial begin
        t2_kind[0] = 2'd0; t2_kind[1] = 2'd1; t2_kind[2] = 2'd2; t2_kind[3] = 2'd1;
        t2_dest[0] = 3'd0; t2_dest[1] = 3'd1; t2_dest[2] = 3'd0; t2_dest[3] = 3'd7;

        do_reset();
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // single load, response two cycles later
        req(2'd1, 3'd5, 16'h0040);
        #1;
        chk("t1_mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_mem_req_we", 32'(mem_req_we), 32'd0);
        chk("t1_mem_req_addr", 32'(mem_req_addr), 32'h0040);
        cyc(); idle();
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        cyc();
        resp(16'hBEEF);
        cyc(); idle();
        chk("t1_ld_valid", 32'(ld_resp_valid), 32'd1);
        chk("t1_resp_data", 32'(resp_data), 32'hBEEF);
        chk("t1_resp_dest", 32'(resp_dest), 32'd5);
        chk("t1_outstanding0", 32'(outstanding), 32'd0);
        cyc();

        // four mixed requests fill the tracker, then in-order completions
        for (int i = 0; i < 4; i++) begin
            req(t2_kind[i], t2_dest[i], 16'(16'h0100 + i));
            cyc();
        end
        idle();
        chk("t2_ready_full", 32'(req_ready), 32'd0);
        chk("t2_outstanding", 32'(outstanding), 32'd4);
        for (int i = 0; i < 4; i++) begin
            resp(16'(16'h1111 * (i + 1)));
            cyc(); idle();
            chk("t2_fetch", 32'(fetch_resp_valid), 32'(t2_kind[i] == 2'd0));
            chk("t2_ld",    32'(ld_resp_valid),    32'(t2_kind[i] == 2'd1));
            chk("t2_st",    32'(st_resp_valid),    32'(t2_kind[i] == 2'd2));
            chk("t2_data",  32'(resp_data),        32'(16'h1111 * (i + 1)));
            if (t2_kind[i] == 2'd1) chk("t2_dest", 32'(resp_dest), 32'(t2_dest[i]));
        end

        // full plus new request plus response in the same cycle
        for (int i = 0; i < 4; i++) begin
            req(2'd0, 3'd0, 16'(16'h0200 + i));
            cyc();
        end
        req(2'd0, 3'd0, 16'h0300);
        resp(16'hA000);
        #1;
        chk("t3_no_accept", 32'(mem_req_valid), 32'd0);
        chk("t3_ready0", 32'(req_ready), 32'd0);
        cyc(); idle();
        chk("t3_outstanding", 32'(outstanding), 32'd3);
        chk("t3_ready1", 32'(req_ready), 32'd1);
        chk("t3_fetch", 32'(fetch_resp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            resp(16'(16'hA001 + i));
            cyc(); idle();
        end
        chk("t3_drained", 32'(outstanding), 32'd0);

        // occupancy 2, simultaneous accept and response
        req(2'd1, 3'd2, 16'h0400); cyc();
        req(2'd2, 3'd0, 16'h0402); cyc();
        req(2'd1, 3'd6, 16'h0404);
        resp(16'hC0DE);
        #1;
        chk("t4_accept", 32'(mem_req_valid), 32'd1);
        cyc(); idle();
        chk("t4_outstanding", 32'(outstanding), 32'd2);
        chk("t4_ld", 32'(ld_resp_valid), 32'd1);
        chk("t4_dest", 32'(resp_dest), 32'd2);
        chk("t4_data", 32'(resp_data), 32'hC0DE);
        resp(16'hC0DF); cyc();
        resp(16'hC0E0); cyc(); idle();
        chk("t4_ld_last", 32'(ld_resp_valid), 32'd1);
        chk("t4_dest_last", 32'(resp_dest), 32'd6);
        chk("t4_drained", 32'(outstanding), 32'd0);
        chk("t4_err_clean", 32'(err_sticky), 32'd0);

        // unexpected response
        resp(16'hDEAD);
        cyc(); idle();
        chk("t5_err_unexp", 32'(err_sticky), 32'd1);
        chk("t5_no_pulse", 32'({fetch_resp_valid, ld_resp_valid, st_resp_valid}), 32'd0);
        cyc();
        chk("t5_err_hold", 32'(err_sticky), 32'd1);

        // illegal kind after a fresh reset
        do_reset();
        chk("t5_err_cleared", 32'(err_sticky), 32'd0);
        req(2'd3, 3'd1, 16'h0500);
        #1;
        chk("t5_illegal_noreq", 32'(mem_req_valid), 32'd0);
        cyc(); idle();
        chk("t5_err_illegal", 32'(err_sticky), 32'd1);
        chk("t5_illegal_occ", 32'(outstanding), 32'd0);

        // asynchronous reset mid-flight with three outstanding
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(2'd1, 3'(i + 1), 16'(16'h0600 + i));
            cyc();
        end
        idle();
        resp(16'h7777);
        cyc(); idle();
        chk("t6_outstanding3", 32'(outstanding), 32'd3);
        chk("t6_ld_before", 32'(ld_resp_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_occ", 32'(outstanding), 32'd0);
        chk("t6_async_ld", 32'(ld_resp_valid), 32'd0);
        chk("t6_async_data", 32'(resp_data), 32'd0);
        chk("t6_async_dest", 32'(resp_dest), 32'd0);
`ifdef MEM_REQ_TRACKER_STATS_EN
        chk("t6_fetch_cnt0", fetch_cnt, 32'd0);
        chk("t6_ld_cnt0", ld_cnt, 32'd0);
        chk("t6_st_cnt0", st_cnt, 32'd0);
`endif
        cyc();
        reset = 1'b1;
        cyc();
        resp(16'h8888);
        cyc(); idle();
        chk("t6_late_err", 32'(err_sticky), 32'd1);
        chk("t6_late_nopulse", 32'({fetch_resp_valid, ld_resp_valid, st_resp_valid}), 32'd0);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            req_valid      = ($urandom_range(0, 99) < 60);
            req_kind       = ($urandom_range(0, 99) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
            req_dest       = 3'($urandom);
            req_addr       = 16'($urandom);
            req_wdata      = 16'($urandom);
            mem_resp_valid = ($urandom_range(0, 99) < 50);
            mem_resp_rdata = 16'($urandom);
            reset          = ($urandom_range(0, 299) != 0);
            cyc();
        end
        idle();
        reset = 1'b1;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
